// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms on start, captures a fixed number of vsync-delimited
// frames into a buffer, and reports completion, timeout or illegal-state faults.
module frame_capture_ctrl #(
  parameter int NFRAMES_W = 4,
  parameter int TIMEOUT_W = 24,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NFRAMES_W-1:0] num_frames,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 abort,
  input  logic                 ack,
  input  logic                 vsync,
  output logic                 wen,
  output logic                 started,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [NFRAMES_W-1:0] frame_idx,
  output logic                 frame_tick
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ZERO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  state_t                 state, state_nxt;
  logic                   vs_act, vs_act_q, vs_edge;
  logic                   tmo_hit;
  logic [NFRAMES_W-1:0]   count_q, count_nxt;
  logic [NFRAMES_W-1:0]   frame_idx_nxt, frame_idx_inc;
  logic [TIMEOUT_W-1:0]   tmo_cnt, tmo_nxt, tmo_inc;
  logic [1:0]             err_code_nxt;
  logic                   frame_tick_nxt;

  assign vs_act        = (vsync == VSYNC_POL);
  assign vs_edge       = vs_act & ~vs_act_q;
  assign frame_idx_inc = frame_idx + NFRAMES_W'(1);
  assign tmo_inc       = tmo_cnt + TIMEOUT_W'(1);
  // The wait phase lasts exactly `timeout` cycles before the fault is taken.
  assign tmo_hit       = (timeout != '0) && (tmo_inc == timeout);

  always_comb begin
    state_nxt      = state;
    count_nxt      = count_q;
    frame_idx_nxt  = frame_idx;
    tmo_nxt        = tmo_cnt;
    err_code_nxt   = err_code;
    frame_tick_nxt = 1'b0;
    wen            = 1'b0;
    started        = 1'b0;
    done           = 1'b0;
    error          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (num_frames != '0) begin
            state_nxt     = ARM;
            count_nxt     = num_frames;
            frame_idx_nxt = '0;
            tmo_nxt       = '0;
          end else begin
            state_nxt    = ERROR;
            err_code_nxt = ERR_ZERO;
          end
        end
      end

      ARM: begin
        started = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          tmo_nxt   = '0;
        end else if (vs_edge) begin
          state_nxt = CAPTURE;
          tmo_nxt   = '0;
        end else if (tmo_hit) begin
          state_nxt    = ERROR;
          err_code_nxt = ERR_TIMEOUT;
        end else begin
          tmo_nxt = tmo_inc;
        end
      end

      CAPTURE: begin
        wen     = 1'b1;
        started = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          tmo_nxt   = '0;
        end else if (vs_edge) begin
          // Each active edge closes one frame; the last one ends the capture.
          frame_idx_nxt  = frame_idx_inc;
          frame_tick_nxt = 1'b1;
          tmo_nxt        = '0;
          if (frame_idx_inc == count_q) begin
            state_nxt = DONE;
          end
        end else if (tmo_hit) begin
          state_nxt    = ERROR;
          err_code_nxt = ERR_TIMEOUT;
        end else begin
          tmo_nxt = tmo_inc;
        end
      end

      DONE: begin
        done = 1'b1;
        if (ack) begin
          state_nxt = IDLE;
        end
      end

      ERROR: begin
        error = 1'b1;
        if (ack) begin
          state_nxt    = IDLE;
          err_code_nxt = ERR_NONE;
        end
      end

      default: begin
        state_nxt    = ERROR;
        err_code_nxt = ERR_ILLEGAL;
      end
    endcase
  end

  // vs_act_q resets high so an already-active vsync is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      vs_act_q   <= 1'b1;
      count_q    <= '0;
      frame_idx  <= '0;
      tmo_cnt    <= '0;
      err_code   <= ERR_NONE;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_act_q   <= vs_act;
      count_q    <= count_nxt;
      frame_idx  <= frame_idx_nxt;
      tmo_cnt    <= tmo_nxt;
      err_code   <= err_code_nxt;
      frame_tick <= frame_tick_nxt;
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: a phase-level reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_frame_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, ack, vsync;
  logic [3:0]  num_frames;
  logic [23:0] timeout;
  logic        wen, started, done, error, frame_tick;
  logic [1:0]  err_code;
  logic [3:0]  frame_idx;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;
  int wen_seen = 0;

  frame_capture_ctrl #(.NFRAMES_W(4), .TIMEOUT_W(24), .VSYNC_POL(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .num_frames(num_frames),
    .timeout(timeout), .abort(abort), .ack(ack), .vsync(vsync),
    .wen(wen), .started(started), .done(done), .error(error),
    .err_code(err_code), .frame_idx(frame_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the capture phase as flags and counts, stepped once per clock.
  bit         m_valid = 0;
  bit         m_armed, m_capturing, m_finished, m_faulted, m_tick;
  bit         m_prev_act = 1;
  int         m_frames, m_target, m_waited;
  logic [1:0] m_code;

  task automatic modelStep();
    bit act, rise;
    if (!reset) begin
      m_valid = 1; m_armed = 0; m_capturing = 0; m_finished = 0; m_faulted = 0;
      m_tick = 0; m_prev_act = 1; m_frames = 0; m_waited = 0; m_code = 2'b00;
      return;
    end
    act = (vsync == 1'b1);
    rise = act && !m_prev_act;
    m_prev_act = act;
    m_tick = 0;
    if (m_finished || m_faulted) begin
      if (ack) begin m_finished = 0; m_faulted = 0; m_code = 2'b00; end
    end else if (m_armed || m_capturing) begin
      if (abort) begin
        m_armed = 0; m_capturing = 0;
      end else if (rise) begin
        m_waited = 0;
        if (m_armed) begin
          m_armed = 0; m_capturing = 1;
        end else begin
          m_frames++; m_tick = 1;
          if (m_frames == m_target) begin m_capturing = 0; m_finished = 1; end
        end
      end else begin
        m_waited++;
        if (timeout != 0 && m_waited == int'(timeout)) begin
          m_armed = 0; m_capturing = 0; m_faulted = 1; m_code = 2'b10;
        end
      end
    end else if (start) begin
      if (num_frames == 0) begin
        m_faulted = 1; m_code = 2'b01;
      end else begin
        m_armed = 1; m_target = int'(num_frames); m_frames = 0; m_waited = 0;
      end
    end
  endtask

  always @(posedge clk) modelStep();

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("wen", 32'(wen), 32'(m_capturing));
      checkOutput("started", 32'(started), 32'(m_armed || m_capturing));
      checkOutput("done", 32'(done), 32'(m_finished));
      checkOutput("error", 32'(error), 32'(m_faulted));
      checkOutput("err_code", 32'(err_code), 32'(m_code));
      checkOutput("frame_idx", 32'(frame_idx), 32'(m_frames));
      checkOutput("frame_tick", 32'(frame_tick), 32'(m_tick));
    end
    if (frame_tick === 1'b1) tick_seen++;
    if (wen === 1'b1) wen_seen++;
  end

  task automatic applyStimulus(input logic st, input logic ab, input logic ak,
                               input logic vs, input int n);
    start = st; abort = ab; ack = ak; vsync = vs;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, k;
    reset = 1'b0; num_frames = 4'd3; timeout = 24'd0;
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_err_code", 32'(err_code), 0);
    checkOutput("reset_frame_idx", 32'(frame_idx), 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 2);

    // Three frames at a 100-cycle vsync period.
    base = tick_seen;
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("start_latency_started", 32'(started), 1);
    applyStimulus(0, 0, 0, 0, 5);
    for (int f = 0; f < 4; f++) begin
      applyStimulus(0, 0, 0, 1, 10);
      applyStimulus(0, 0, 0, 0, 90);
    end
    checkOutput("three_frames_done", 32'(done), 1);
    checkOutput("three_frames_idx", 32'(frame_idx), 3);
    checkOutput("three_frames_ticks", 32'(tick_seen - base), 3);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("ack_clears_done", 32'(done), 0);
    applyStimulus(0, 0, 0, 0, 2);

    // Zero frames requested, then start+ack together only returns to idle.
    num_frames = 4'd0;
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("zero_frames_error", 32'(error), 1);
    checkOutput("zero_frames_code", 32'(err_code), 1);
    applyStimulus(0, 0, 0, 0, 3);
    num_frames = 4'd2;
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("ack_clears_code", 32'(err_code), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("start_with_ack_ignored", 32'(started), 0);
    applyStimulus(0, 0, 0, 0, 2);

    // Timeout of 50 with vsync held inactive.
    timeout = 24'd50;
    base = wen_seen;
    applyStimulus(1, 0, 0, 0, 1);
    k = 0;
    while (k < 100) begin
      k++;
      applyStimulus(0, 0, 0, 0, 1);
      if (error === 1'b1) break;
    end
    checkOutput("timeout_latency", 32'(k), 50);
    checkOutput("timeout_code", 32'(err_code), 2);
    checkOutput("timeout_no_wen", 32'(wen_seen - base), 0);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 2);

    // Edge arriving on the same cycle the timeout would expire wins.
    timeout = 24'd20;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 19);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("edge_beats_timeout_wen", 32'(wen), 1);
    checkOutput("edge_beats_timeout_err", 32'(error), 0);
    applyStimulus(0, 1, 0, 1, 1);
    checkOutput("abort_capture_started", 32'(started), 0);
    applyStimulus(0, 0, 0, 0, 3);

    // Abort coinciding with the second frame-closing edge of a 4-frame capture.
    timeout = 24'd0; num_frames = 4'd4;
    applyStimulus(1, 0, 0, 0, 1);
    for (int f = 0; f < 2; f++) begin
      applyStimulus(0, 0, 0, 0, 5);
      applyStimulus(0, 0, 0, 1, 3);
    end
    applyStimulus(0, 0, 0, 0, 5);
    applyStimulus(0, 1, 0, 1, 1);
    checkOutput("abort_wen", 32'(wen), 0);
    checkOutput("abort_tick", 32'(frame_tick), 0);
    checkOutput("abort_idx", 32'(frame_idx), 1);
    applyStimulus(0, 0, 0, 0, 3);

    // Largest frame count completes without wrapping.
    num_frames = 4'd15;
    applyStimulus(1, 0, 0, 0, 1);
    for (int f = 0; f < 16; f++) begin
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 2);
    end
    checkOutput("max_frames_done", 32'(done), 1);
    checkOutput("max_frames_idx", 32'(frame_idx), 15);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 2);

    // Reset mid-capture with vsync held active; no false edge afterwards.
    num_frames = 4'd4;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 4);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 2);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("reset_mid_wen", 32'(wen), 0);
    checkOutput("reset_mid_started", 32'(started), 0);
    num_frames = 4'd2;
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 5);
    checkOutput("no_false_edge_wen", 32'(wen), 0);
    checkOutput("no_false_edge_started", 32'(started), 1);
    applyStimulus(0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("real_edge_wen", 32'(wen), 1);
    applyStimulus(0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL provide parameter NFRAMES_W, default 4, width of frame count and frame index.
REQ-002 SHALL provide parameter TIMEOUT_W, default 24, width of timeout counter and timeout input.
REQ-003 SHALL provide parameter VSYNC_POL, default 1, vsync level treated as active.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all logic on rising edge
  reset  in  1  synchronous, active-low reset
  start  in  1  request capture; sampled only in IDLE
  num_frames  in  NFRAMES_W  frames to capture; sampled on accepted start
  timeout  in  TIMEOUT_W  max cycles between active vsync edges; 0 = disabled
  abort  in  1  cancel capture in ARM/CAPTURE
  ack  in  1  acknowledge DONE/ERROR
  vsync  in  1  frame sync, synchronous to clk
  wen  out  1  frame-buffer write enable
  started  out  1  capture in progress
  done  out  1  capture complete, held until ack
  error  out  1  fault, held until ack
  err_code  out  2  01 zero frames, 10 timeout, 11 illegal state, 00 none
  frame_idx  out  NFRAMES_W  frames completed in current capture
  frame_tick  out  1  one-cycle pulse per completed frame

Function
REQ-005 SHALL define vs_act = (vsync == VSYNC_POL), register it as vs_act_q, and define edge = vs_act & ~vs_act_q.
REQ-006 SHALL implement states IDLE, ARM, CAPTURE, DONE, ERROR; any other encoding SHALL go to ERROR with err_code 11 next cycle.
REQ-007 IDLE: start=1 and num_frames!=0 -> ARM; latch num_frames, clear frame_idx and timeout counter; start=1 and num_frames==0 -> ERROR, err_code 01.
REQ-008 ARM: edge -> CAPTURE; wen=0, started=1.
REQ-009 CAPTURE: wen=1, started=1; on edge, frame_idx increments and frame_tick=1 for that cycle; if the incremented frame_idx equals latched count -> DONE, else remain CAPTURE.
REQ-010 DONE: done=1, wen=0, started=0; ack=1 -> IDLE.
REQ-011 ERROR: error=1, wen=0, started=0; ack=1 -> IDLE, err_code cleared to 00 on exit.
REQ-012 Outputs wen, started, done, error SHALL be decoded from current state only (Moore); frame_tick and frame_idx SHALL be registered.
REQ-013 Latency: start accepted in cycle n -> started=1 in n+1; edge in cycle m in ARM -> wen=1 in m+1; final edge in cycle m -> done=1 and wen=0 in m+1.
REQ-014 Timeout counter SHALL count cycles in ARM/CAPTURE, clear on every edge and on state entry; when timeout!=0 and counter reaches timeout -> ERROR, err_code 10.
REQ-015 abort=1 in ARM or CAPTURE SHALL go to IDLE next cycle with wen=0; abort SHALL take priority over edge and timeout in the same cycle; frame_idx retains its value.
REQ-016 Edge and timeout in same cycle: edge SHALL win (counter cleared).
REQ-017 start outside IDLE SHALL be ignored; start and ack together in DONE/ERROR SHALL go to IDLE only, capture not started.
REQ-018 abort and ack SHALL be ignored in states where not listed.
REQ-019 frame_idx SHALL never exceed latched count; num_frames of 2^NFRAMES_W-1 SHALL complete without wrap.

Reset
REQ-020 reset=0 at clock edge SHALL force IDLE, vs_act_q=1, frame_idx=0, timeout counter=0, err_code=00, frame_tick=0, wen=started=done=error=0, from any state including mid-capture.
REQ-021 vs_act_q reset to 1 SHALL prevent a false edge when vsync is already active at reset release.

Verification
REQ-022 num_frames=3, timeout=0, vsync period 100 cycles -> wen=1 spans three frames, frame_tick pulses 3 times, frame_idx 1,2,3, done=1 until ack, then IDLE.
REQ-023 start with num_frames=0 -> error=1, err_code=01 next cycle; ack -> err_code=00, IDLE.
REQ-024 timeout=50, vsync held inactive after start -> error=1, err_code=10 at 50 cycles in ARM, wen never asserted.
REQ-025 abort in same cycle as second edge of num_frames=4 capture -> IDLE next cycle, wen=0, frame_tick=0, frame_idx=1.
REQ-026 reset=0 asserted mid-CAPTURE with vsync active, then released -> all outputs 0, no ARM->CAPTURE until vsync goes inactive then active after a new start.
